// File: rtl/rr_arb_mux.sv
// Registered N:1 arbitrating multiplexer.
// Round-robin or fixed-priority grant feeding a one-hot AND-OR mux into one output register.
module rr_arb_mux #(
  parameter type T       = logic,
  parameter int  NUM_CH  = 4,
  parameter bit  RR_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_valid,
  input  T                  in_data [NUM_CH-1:0],
  output logic [NUM_CH-1:0] in_ready,
  output logic              out_valid,
  output T                  out_data,
  output logic [NUM_CH-1:0] out_grant,
  input  logic              out_ready
);

  localparam int W  = $bits(T);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     sh;
  logic [PW-1:0]     nxt;
  logic [NUM_CH-1:0] rot;
  logic [NUM_CH-1:0] rot_oh;
  logic [NUM_CH-1:0] grant_oh;
  logic [W-1:0]      lane [NUM_CH];
  logic [W-1:0]      mux;
  logic              load;
  logic              any;

  // Fixed priority is round-robin with the search origin pinned to 0.
  assign sh   = RR_MODE ? ptr : '0;
  assign load = ~out_valid | out_ready;
  assign any  = |in_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign lane[g] = in_data[g];
  end

  // Rotate requests so ptr sits at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    rot      = NUM_CH'({in_valid, in_valid} >> sh);
    rot_oh   = rot & (~rot + NUM_CH'(1));
    grant_oh = NUM_CH'(({rot_oh, rot_oh} << sh) >> NUM_CH);
  end

  assign in_ready = grant_oh & {NUM_CH{load}};

  // One-hot AND-OR payload steering.
  always_comb begin
    mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mux = mux | (lane[i] & {W{grant_oh[i]}});
    end
  end

  // Pointer moves to the channel just after the winner.
  always_comb begin
    nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_oh[i]) nxt = PW'((i + 1) % NUM_CH);
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data  <= T'(mux);
        out_grant <= grant_oh;
        if (RR_MODE) ptr <= nxt;
      end
    end
  end

`ifdef COMM_ASSERT
  a_ready_oh: assert property (@(posedge clk) disable iff (rst)
    $onehot0(in_ready));
  a_grant_oh: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> $onehot(out_grant));
  a_stall: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      ($stable(out_data) && $stable(out_grant) && out_valid));
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed vectors plus an index-level reference model
// and a payload scoreboard, checked every falling edge.
module tb_rr_arb_mux;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] val;
  } pl_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus for the two 4-channel byte instances
  logic [3:0] vld;
  logic [7:0] d8 [3:0];
  logic       ordy;
  // struct instance stimulus
  logic [2:0] vc;
  pl_t        dc [2:0];
  logic       ordc;

  logic [3:0] rdy_a, gnt_a, rdy_b, gnt_b;
  logic       ov_a, ov_b, ov_c;
  logic [7:0] od_a, od_b;
  logic [2:0] rdy_c, gnt_c;
  pl_t        od_c;

  rr_arb_mux #(.T(logic [7:0]), .NUM_CH(4), .RR_MODE(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(vld), .in_data(d8),
    .in_ready(rdy_a), .out_valid(ov_a), .out_data(od_a),
    .out_grant(gnt_a), .out_ready(ordy));

  rr_arb_mux #(.T(logic [7:0]), .NUM_CH(4), .RR_MODE(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(vld), .in_data(d8),
    .in_ready(rdy_b), .out_valid(ov_b), .out_data(od_b),
    .out_grant(gnt_b), .out_ready(ordy));

  rr_arb_mux #(.T(pl_t), .NUM_CH(3), .RR_MODE(1'b1)) u_c (
    .clk(clk), .rst(rst), .in_valid(vc), .in_data(dc),
    .in_ready(rdy_c), .out_valid(ov_c), .out_data(od_c),
    .out_grant(gnt_c), .out_ready(ordc));

  int tests = 0;
  int fails = 0;
  logic c_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state, one slot per instance: 0=A, 1=B, 2=C
  int mv [3];
  int md [3];
  int mg [3];
  int mp [3];
  int nch [3] = '{4, 4, 3};
  int rrm [3] = '{1, 0, 1};
  int sb [$];

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      mv[m] = 0; md[m] = 0; mg[m] = 0; mp[m] = 0;
    end
    sb.delete();
  endtask

  // Check current outputs, then advance the model to the next rising edge.
  task automatic model_step(input int m, input string tag,
                            input logic [3:0] v, input int d [4],
                            input int rdy, input int ov, input int od,
                            input int og, input logic orr,
                            output int acc);
    int n;
    int w;
    int base;
    bit ld;
    n = nch[m];
    w = -1;
    base = (rrm[m] != 0) ? mp[m] : 0;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (base + k) % n;
      if (w < 0 && v[idx[1:0]]) w = idx;
    end
    ld = (mv[m] == 0) || orr;
    check({tag, " out_valid"}, ov, mv[m]);
    check({tag, " out_grant"}, og, mg[m]);
    check({tag, " out_data"}, od, md[m]);
    check({tag, " in_ready"}, rdy, (ld && w >= 0) ? (1 << w) : 0);
    acc = -1;
    if (ld) begin
      if (w >= 0) begin
        mv[m] = 1;
        md[m] = d[w[1:0]];
        mg[m] = 1 << w;
        mp[m] = (w + 1) % n;
        acc = w;
      end else begin
        mv[m] = 0;
      end
    end
  endtask

  // Single compare process against the model and the struct scoreboard.
  always @(negedge clk) begin
    int da [4];
    int dcx [4];
    int acc;
    int e;
    if (rst) begin
      model_reset();
      check("rst A out_valid", 32'(ov_a), 0);
      check("rst B out_valid", 32'(ov_b), 0);
      check("rst C out_valid", 32'(ov_c), 0);
      check("rst C out_grant", 32'(gnt_c), 0);
    end else begin
      for (int i = 0; i < 4; i++) da[i] = 32'(d8[i]);
      for (int i = 0; i < 3; i++) dcx[i] = 32'(dc[i]);
      dcx[3] = 0;
      model_step(0, "A", vld, da, 32'(rdy_a), 32'(ov_a),
                 32'(od_a), 32'(gnt_a), ordy, acc);
      model_step(1, "B", vld, da, 32'(rdy_b), 32'(ov_b),
                 32'(od_b), 32'(gnt_b), ordy, acc);
      if (ov_c && ordc) begin
        if (sb.size() == 0) begin
          check("C sb empty", 32'(ov_c), 0);
        end else begin
          e = sb.pop_front();
          check("C sb data", 32'(od_c), e);
        end
      end
      model_step(2, "C", {1'b0, vc}, dcx, 32'(rdy_c), 32'(ov_c),
                 32'(od_c), 32'(gnt_c), ordc, acc);
      if (acc >= 0) sb.push_back(dcx[acc[1:0]]);
    end
  end

  logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  // Directed sequence on the byte instances.
  initial begin
    rst = 1'b1;
    vld = '0;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) d8[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // round-robin sweep
    d8[0] = 8'h11; d8[1] = 8'h22; d8[2] = 8'h33; d8[3] = 8'h44;
    vld = 4'hF;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("sweep valid", 32'(ov_a), 1);
      check("sweep grant", 32'(gnt_a), 32'(exp_g[k]));
      check("sweep data", 32'(od_a), 32'(exp_d[k]));
    end
    // stall holding ch1's beat
    @(posedge clk);
    #1 ordy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall in_ready", 32'(rdy_a), 0);
      check("stall data", 32'(od_a), 32'h22);
      check("stall grant", 32'(gnt_a), 32'h2);
    end
    @(posedge clk);
    #1 ordy = 1'b1;
    @(negedge clk);
    check("release in_ready", 32'(rdy_a), 32'h4);
    @(negedge clk);
    check("release grant", 32'(gnt_a), 32'h4);
    check("release data", 32'(od_a), 32'h33);
    // fixed priority
    @(posedge clk);
    #1 vld = 4'b1010;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      check("fixed grant", 32'(gnt_b), 32'h2);
      check("fixed data", 32'(od_b), 32'h22);
      check("fixed in_ready", 32'(rdy_b), 32'h2);
    end
    // sparse request and pointer wrap
    @(posedge clk);
    #1 vld = 4'b0100;
    @(posedge clk);
    #1 vld = 4'b0001;
    @(negedge clk);
    check("wrap in_ready", 32'(rdy_a), 32'h1);
    check("wrap prev grant", 32'(gnt_a), 32'h4);
    @(posedge clk);
    #1 vld = 4'b0000;
    @(negedge clk);
    check("wrap grant", 32'(gnt_a), 32'h1);
    check("wrap data", 32'(od_a), 32'h11);
    @(negedge clk);
    check("idle valid", 32'(ov_a), 0);
    check("idle data hold", 32'(od_a), 32'h11);
    vld = 4'hF;
    #1 check("ptr after wrap", 32'(rdy_a), 32'h2);
    // asynchronous reset during a stall
    @(posedge clk);
    #1 ordy = 1'b0;
    @(posedge clk);
    #3 check("pre-rst valid", 32'(ov_a), 1);
    rst = 1'b1;
    #1;
    check("async rst valid", 32'(ov_a), 0);
    check("async rst data", 32'(od_a), 0);
    check("async rst grant", 32'(gnt_a), 0);
    check("async rst C data", 32'(od_c), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-rst ptr", 32'(rdy_a), 32'h1);
    ordy = 1'b1;
    wait (c_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Struct instance: one directed beat then random traffic.
  initial begin
    vc = '0;
    ordc = 1'b1;
    for (int i = 0; i < 3; i++) dc[i] = '0;
    @(negedge rst);
    @(posedge clk);
    #1 vc = 3'b100;
    dc[2].op = 4'hA;
    dc[2].val = 16'hBEEF;
    @(posedge clk);
    #1 vc = 3'b000;
    check("struct op", 32'(od_c.op), 32'hA);
    check("struct val", 32'(od_c.val), 32'hBEEF);
    check("struct grant", 32'(gnt_c), 32'h4);
    repeat (10000) begin
      @(posedge clk);
      #1 vc = 3'($urandom);
      for (int i = 0; i < 3; i++) dc[i] = pl_t'(20'($urandom));
      ordc = ($urandom_range(0, 3) != 0);
    end
    c_done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, tests %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
